// File: rtl/fpnew_classify.sv
// fpnew_classify: pipelined fclass-style decoder producing a 10-bit class mask, sign and tag.
// Define FPNEW_CLASSIFY_STICKY_EN to add the nv_sticky_o / clear_sticky_i invalid flag.
package fpnew_pkg;
  typedef enum logic [2:0] {FP32, FP64, FP16, FP8, FP16ALT} fp_format_e;
  function automatic int unsigned exp_bits(input fp_format_e f);
    return (f == FP64) ? 11 : (f == FP16 || f == FP8) ? 5 : 8;
  endfunction
  function automatic int unsigned man_bits(input fp_format_e f);
    return (f == FP64) ? 52 : (f == FP16) ? 10 : (f == FP8) ? 2 : (f == FP16ALT) ? 7 : 23;
  endfunction
endpackage

module fpnew_classify #(
  parameter fpnew_pkg::fp_format_e FpFormat = fpnew_pkg::FP32,
  parameter int unsigned NumPipeRegs = 1,
  parameter int unsigned TagWidth = 4,
  parameter bit NanBoxCheck = 1'b1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                flush_i,
  input  logic [63:0]         operand_i,
  input  logic [TagWidth-1:0] tag_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  output logic [9:0]          class_o,
  output logic                sign_o,
  output logic [TagWidth-1:0] tag_o,
  output logic                out_valid_o,
  input  logic                out_ready_i
`ifdef FPNEW_CLASSIFY_STICKY_EN
  ,
  output logic                nv_sticky_o,
  input  logic                clear_sticky_i
`endif
);
  localparam int unsigned EB = fpnew_pkg::exp_bits(FpFormat);
  localparam int unsigned MB = fpnew_pkg::man_bits(FpFormat);
  localparam int unsigned W  = 1 + EB + MB;
  localparam int unsigned DW = 11 + TagWidth;
  logic                 w_boxed, w_sign, w_ones, w_ezero, w_mzero, w_norm;
  logic [W-1:0]         w_val;
  logic [EB-1:0]        w_exp;
  logic [MB-1:0]        w_man;
  logic [9:0]           w_class;
  logic [NumPipeRegs:0] w_v, w_ready;
  logic [DW-1:0]        w_d [NumPipeRegs+1];
  if (W < 64) begin : g_box
    assign w_boxed = ~NanBoxCheck | (&operand_i[63:W]);
  end else begin : g_nobox
    assign w_boxed = 1'b1;
  end
  // an improperly boxed narrow value decodes as the canonical qNaN
  assign w_val = w_boxed ? operand_i[W-1:0] : {1'b0, {EB{1'b1}}, 1'b1, {(MB-1){1'b0}}};
  assign {w_sign, w_exp, w_man} = w_val;
  assign w_ones  = &w_exp;
  assign w_ezero = ~|w_exp;
  assign w_mzero = ~|w_man;
  assign w_norm  = ~w_ones & ~w_ezero;
  assign w_class = {w_ones & w_man[MB-1],
                    w_ones & ~w_man[MB-1] & ~w_mzero,
                    w_ones & w_mzero & ~w_sign,
                    w_norm & ~w_sign,
                    w_ezero & ~w_mzero & ~w_sign,
                    w_ezero & w_mzero & ~w_sign,
                    w_ezero & w_mzero & w_sign,
                    w_ezero & ~w_mzero & w_sign,
                    w_norm & w_sign,
                    w_ones & w_mzero & w_sign};
  assign w_v[0]               = in_valid_i;
  assign w_d[0]               = {w_class, w_sign, tag_i};
  assign w_ready[NumPipeRegs] = out_ready_i;
  for (genvar s = 0; s < NumPipeRegs; s++) begin : g_stage
    logic          r_v;
    logic [DW-1:0] r_d;
    assign w_ready[s] = ~r_v | w_ready[s+1];
    always_ff @(posedge clk_i)
      if (rst_i) begin
        r_v <= 1'b0;
        r_d <= '0;
      end else begin
        r_v <= ~flush_i & (w_ready[s] ? w_v[s] : r_v);
        if (w_ready[s]) r_d <= w_d[s];
      end
    assign w_v[s+1] = r_v;
    assign w_d[s+1] = r_d;
  end
  assign in_ready_o                = w_ready[0];
  assign out_valid_o               = w_v[NumPipeRegs];
  assign {class_o, sign_o, tag_o}  = w_d[NumPipeRegs];
`ifdef FPNEW_CLASSIFY_STICKY_EN
  logic r_sticky;
  always_ff @(posedge clk_i)
    r_sticky <= rst_i ? 1'b0 : (out_valid_o & out_ready_i & class_o[8]) | (r_sticky & ~clear_sticky_i);
  assign nv_sticky_o = r_sticky;
`endif
endmodule

// File: tb/tb_fpnew_classify.sv
// tb_fpnew_classify: directed checks of decode, boxing, pipeline flow control, flush/reset and sticky flag.
module tb_fpnew_classify;
  logic clk, rst, flush;
  int   n_checks, n_errors;
  logic [63:0] a_op, b_op, c_op;
  logic [3:0]  a_tag, b_tag, c_tag, a_tag_o, b_tag_o, c_tag_o, d_tag_o;
  logic        a_valid, b_valid, c_valid, a_ready, b_ready, c_ready;
  logic        a_in_ready, b_in_ready, c_in_ready, d_in_ready;
  logic [9:0]  a_class, b_class, c_class, d_class;
  logic        a_sign, b_sign, c_sign, d_sign;
  logic        a_ovalid, b_ovalid, c_ovalid, d_ovalid;
  logic        a_clr, a_nv, b_nv, c_nv, d_nv;
  int          sent, got, stall, first_cyc;
  logic        acc;

  logic [63:0] t1_op  [3] = '{64'hFFFFFFFF_7F800000, 64'hFFFFFFFF_FF800000, 64'hFFFFFFFF_00000000};
  logic [9:0]  t1_cls [3] = '{10'h080, 10'h001, 10'h010};
  logic [63:0] t2_op  [4] = '{64'hFFFFFFFF_7FC00000, 64'hFFFFFFFF_7FA00000, 64'hFFFFFFFF_80000001, 64'hFFFFFFFF_3F800000};
  logic [9:0]  t2_cls [4] = '{10'h200, 10'h100, 10'h004, 10'h040};
  logic        t2_sgn [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
  logic [63:0] t4_op  [6] = '{64'hFFFFFFFF_7F800000, 64'hFFFFFFFF_FF800000, 64'hFFFFFFFF_00000000,
                              64'hFFFFFFFF_7FC00000, 64'hFFFFFFFF_7FA00000, 64'hFFFFFFFF_80000001};
  logic [9:0]  t4_cls [6] = '{10'h080, 10'h001, 10'h010, 10'h200, 10'h100, 10'h004};

  fpnew_classify #(.FpFormat(fpnew_pkg::FP32), .NumPipeRegs(1), .TagWidth(4), .NanBoxCheck(1'b1)) u_a (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .operand_i(a_op), .tag_i(a_tag), .in_valid_i(a_valid),
    .in_ready_o(a_in_ready), .class_o(a_class), .sign_o(a_sign), .tag_o(a_tag_o), .out_valid_o(a_ovalid),
    .out_ready_i(a_ready)
`ifdef FPNEW_CLASSIFY_STICKY_EN
    , .nv_sticky_o(a_nv), .clear_sticky_i(a_clr)
`endif
  );
  fpnew_classify #(.FpFormat(fpnew_pkg::FP32), .NumPipeRegs(2), .TagWidth(4), .NanBoxCheck(1'b1)) u_b (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .operand_i(b_op), .tag_i(b_tag), .in_valid_i(b_valid),
    .in_ready_o(b_in_ready), .class_o(b_class), .sign_o(b_sign), .tag_o(b_tag_o), .out_valid_o(b_ovalid),
    .out_ready_i(b_ready)
`ifdef FPNEW_CLASSIFY_STICKY_EN
    , .nv_sticky_o(b_nv), .clear_sticky_i(1'b0)
`endif
  );
  fpnew_classify #(.FpFormat(fpnew_pkg::FP16), .NumPipeRegs(0), .TagWidth(4), .NanBoxCheck(1'b1)) u_c (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .operand_i(c_op), .tag_i(c_tag), .in_valid_i(c_valid),
    .in_ready_o(c_in_ready), .class_o(c_class), .sign_o(c_sign), .tag_o(c_tag_o), .out_valid_o(c_ovalid),
    .out_ready_i(c_ready)
`ifdef FPNEW_CLASSIFY_STICKY_EN
    , .nv_sticky_o(c_nv), .clear_sticky_i(1'b0)
`endif
  );
  fpnew_classify #(.FpFormat(fpnew_pkg::FP16), .NumPipeRegs(0), .TagWidth(4), .NanBoxCheck(1'b0)) u_d (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .operand_i(c_op), .tag_i(c_tag), .in_valid_i(c_valid),
    .in_ready_o(d_in_ready), .class_o(d_class), .sign_o(d_sign), .tag_o(d_tag_o), .out_valid_o(d_ovalid),
    .out_ready_i(c_ready)
`ifdef FPNEW_CLASSIFY_STICKY_EN
    , .nv_sticky_o(d_nv), .clear_sticky_i(1'b0)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    rst = 1'b1; flush = 1'b0;
    a_op = '0; a_tag = '0; a_valid = 1'b0; a_ready = 1'b1; a_clr = 1'b0;
    b_op = '0; b_tag = '0; b_valid = 1'b0; b_ready = 1'b1;
    c_op = '0; c_tag = '0; c_valid = 1'b0; c_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_a_valid", 64'(a_ovalid), 0);
    chk("rst_a_class", 64'(a_class), 0);
    chk("rst_a_sign",  64'(a_sign), 0);
    chk("rst_a_tag",   64'(a_tag_o), 0);
    chk("rst_b_valid", 64'(b_ovalid), 0);
    chk("rst_b_class", 64'(b_class), 0);
    rst = 1'b0;
    // back-to-back specials through the single-stage instance
    for (int i = 0; i < 3; i++) begin
      a_op = t1_op[i]; a_tag = 4'(i); a_valid = 1'b1;
      #1 chk("t1_in_ready", 64'(a_in_ready), 1);
      @(posedge clk); #1;
      chk("t1_valid", 64'(a_ovalid), 1);
      chk("t1_class", 64'(a_class), 64'(t1_cls[i]));
      chk("t1_tag",   64'(a_tag_o), 64'(i));
    end
    for (int i = 0; i < 4; i++) begin
      a_op = t2_op[i]; a_tag = 4'(i + 3); a_valid = 1'b1;
      @(posedge clk); #1;
      chk("t2_class", 64'(a_class), 64'(t2_cls[i]));
      chk("t2_sign",  64'(a_sign), 64'(t2_sgn[i]));
    end
    a_valid = 1'b0;
    @(posedge clk); #1;
    chk("t2_drain_valid", 64'(a_ovalid), 0);
`ifdef FPNEW_CLASSIFY_STICKY_EN
    a_clr = 1'b1;
    @(posedge clk); #1;
    a_clr = 1'b0;
    chk("st_cleared", 64'(a_nv), 0);
    a_op = 64'hFFFFFFFF_7FA00000; a_valid = 1'b1;
    @(posedge clk); #1;
    a_valid = 1'b0;
    chk("st_snan_class", 64'(a_class), 64'h100);
    chk("st_before_xfer", 64'(a_nv), 0);
    @(posedge clk); #1;
    chk("st_set", 64'(a_nv), 1);
    @(posedge clk); #1;
    chk("st_hold", 64'(a_nv), 1);
    a_clr = 1'b1;
    @(posedge clk); #1;
    a_clr = 1'b0;
    chk("st_clear", 64'(a_nv), 0);
    a_valid = 1'b1;
    @(posedge clk); #1;
    a_valid = 1'b0; a_clr = 1'b1;
    @(posedge clk); #1;
    a_clr = 1'b0;
    chk("st_set_wins", 64'(a_nv), 1);
`endif
    // FP16 combinational instances, with and without the boxing check
    c_valid = 1'b1; c_ready = 1'b1; c_tag = 4'h5;
    c_op = 64'h00000000_00003C00;
    #1;
    chk("t3_unboxed_box",   64'(c_class), 64'h200);
    chk("t3_unboxed_sign",  64'(c_sign), 0);
    chk("t3_unboxed_nobox", 64'(d_class), 64'h040);
    chk("t3_comb_valid",    64'(c_ovalid), 1);
    chk("t3_comb_tag",      64'(c_tag_o), 5);
    c_op = 64'hFFFFFFFF_FFFF3C00;
    #1;
    chk("t3_boxed_box",   64'(c_class), 64'h040);
    chk("t3_boxed_nobox", 64'(d_class), 64'h040);
    c_op = 64'hFFFFFFFF_FFFFFC00;
    #1;
    chk("t3_ninf_class", 64'(c_class), 64'h001);
    chk("t3_ninf_sign",  64'(c_sign), 1);
    c_ready = 1'b0;
    #1;
    chk("t3_ready_pass", 64'(c_in_ready), 0);
    // two-stage pipeline with an output stall
    @(posedge clk); #1;
    sent = 0; got = 0; stall = 0; first_cyc = -1;
    b_ready = 1'b1; b_valid = 1'b1; b_op = t4_op[0]; b_tag = 4'h0;
    for (int cyc = 0; cyc < 60 && got < 6; cyc++) begin
      @(negedge clk);
      chk("t4_in_ready", 64'(b_in_ready), (sent - got < 2 || b_ready) ? 64'd1 : 64'd0);
      if (b_ovalid && got < 6) begin
        if (first_cyc < 0) first_cyc = cyc;
        chk("t4_tag",   64'(b_tag_o), 64'(got));
        chk("t4_class", 64'(b_class), 64'(t4_cls[got]));
        if (b_ready) begin
          if (got == 0) stall = 3;
          got++;
        end
      end
      acc = b_valid && b_in_ready;
      @(posedge clk); #1;
      if (acc) begin
        sent++;
        if (sent < 6) begin
          b_op = t4_op[sent]; b_tag = 4'(sent);
        end else b_valid = 1'b0;
      end
      if (stall > 0) begin
        b_ready = 1'b0; stall--;
      end else b_ready = 1'b1;
    end
    chk("t4_got",     64'(got), 6);
    chk("t4_sent",    64'(sent), 6);
    chk("t4_latency", 64'(first_cyc), 2);
    b_valid = 1'b0; b_ready = 1'b1;
    @(posedge clk); #1;
    chk("t4_empty", 64'(b_ovalid), 0);
    // flush with two ops in flight, plus an input offered during flush
    b_ready = 1'b0; b_valid = 1'b1; b_op = t4_op[3]; b_tag = 4'h9;
    @(posedge clk); #1;
    b_tag = 4'hA;
    @(posedge clk); #1;
    b_valid = 1'b0;
    chk("t5_inflight", 64'(b_ovalid), 1);
    flush = 1'b1;
    @(posedge clk); #1;
    chk("t5_flush_valid", 64'(b_ovalid), 0);
    chk("t5_flush_ready", 64'(b_in_ready), 1);
    b_valid = 1'b1; b_tag = 4'hB;
    @(posedge clk); #1;
    flush = 1'b0; b_valid = 1'b0; b_ready = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      chk("t5_flush_dropped", 64'(b_ovalid), 0);
    end
    // reset with two ops in flight
    b_ready = 1'b0; b_valid = 1'b1; b_op = t4_op[1]; b_tag = 4'hC;
    @(posedge clk); #1;
    b_tag = 4'hD;
    @(posedge clk); #1;
    b_valid = 1'b0;
    chk("t6_inflight", 64'(b_ovalid), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("t6_rst_valid", 64'(b_ovalid), 0);
    chk("t6_rst_class", 64'(b_class), 0);
    chk("t6_rst_sign",  64'(b_sign), 0);
    chk("t6_rst_tag",   64'(b_tag_o), 0);
    rst = 1'b0; b_ready = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      chk("t6_rst_dropped", 64'(b_ovalid), 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
